// File: rtl/tt06_pwm_pkg.sv
// tt06_pwm_pkg: shared constants and duty clamp for the PWM tile
// Exports PERIOD (cycles per PWM period, also the 100 % duty value),
// DC_W (duty input width) and clamp_dc() which saturates duty at PERIOD.
package tt06_pwm_pkg;
    localparam int PERIOD = 100;
    localparam int DC_W = 7;

    function automatic logic [DC_W-1:0] clamp_dc(input logic [DC_W-1:0] dc);
        return (dc > DC_W'(PERIOD)) ? DC_W'(PERIOD) : dc;
    endfunction
endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: modulo-PERIOD cycle counter with period-start strobe
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, forces cnt to 0
//   cnt   - current position in the period, 0..PERIOD-1
//   start - high while cnt == 0, i.e. the next edge begins a period
module pwm_period_counter
    import tt06_pwm_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic [DC_W-1:0] cnt,
    output logic            start
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= (cnt == DC_W'(PERIOD - 1)) ? '0 : cnt + DC_W'(1);
    end

    assign start = (cnt == '0);
endmodule

// File: rtl/tt_um_tt06_pwm.sv
// tt_um_tt06_pwm: single-channel PWM with registered complementary output
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset, clears outputs at once
//   dc       - duty cycle in percent, values above PERIOD act as PERIOD
//   pwm_out  - registered PWM waveform
//   pwm_out1 - registered complement of pwm_out, 0 while in reset
module tt_um_tt06_pwm
    import tt06_pwm_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [DC_W-1:0] dc,
    output logic            pwm_out,
    output logic            pwm_out1
);
    logic [DC_W-1:0] cnt;
    logic            start;
    logic [DC_W-1:0] dc_q;
    logic [DC_W-1:0] dc_clamp;
    logic [DC_W-1:0] dc_eff;
    logic            high;

    pwm_period_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt),
        .start (start)
    );

    // The fresh duty is used directly on the period-start edge so the
    // first cycle of a period already reflects the newly sampled value.
    assign dc_clamp = clamp_dc(dc);
    assign dc_eff   = start ? dc_clamp : dc_q;
    assign high     = (cnt < dc_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_q     <= '0;
            pwm_out  <= 1'b0;
            pwm_out1 <= 1'b0;
        end else begin
            if (start) dc_q <= dc_clamp;
            pwm_out  <= high;
            pwm_out1 <= !high;
        end
    end
endmodule

// File: tb/tb_tt_um_tt06_pwm.sv
// tb_tt_um_tt06_pwm: self-checking bench for tt_um_tt06_pwm
module tb_tt_um_tt06_pwm;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] dc = 7'd50;
    logic       pwm_out;
    logic       pwm_out1;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since release and the duty sampled at period start.
    int  k = 0;
    int  samp = 0;
    logic exp_pwm = 1'b0;
    logic exp_pwm1 = 1'b0;

    typedef struct {
        int dc;
        int high;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    tt_um_tt06_pwm dut (
        .clk      (clk),
        .reset    (reset),
        .dc       (dc),
        .pwm_out  (pwm_out),
        .pwm_out1 (pwm_out1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance the model, then compare shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            exp_pwm  = 1'b0;
            exp_pwm1 = 1'b0;
        end else begin
            if (k % 100 == 0) samp = (int'(dc) > 100) ? 100 : int'(dc);
            exp_pwm  = ((k % 100) < samp);
            exp_pwm1 = !exp_pwm;
            k++;
        end
        #1;
        chk("pwm_out", int'(pwm_out), int'(exp_pwm));
        chk("pwm_out1", int'(pwm_out1), int'(exp_pwm1));
    endtask

    // Assert reset between edges, confirm outputs clear with no clock, hold, release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_pwm1", int'(pwm_out1), 0);
        repeat (2) tick();
        reset = 1'b0;
        k = 0;
        samp = 0;
    endtask

    task automatic align();
        while (k % 100 != 0) tick();
    endtask

    // Run one whole period with duty d and measure its high count and shape.
    task automatic run_period(input int d, input int exp_high, output int highs, output int shape_bad);
        dc = 7'(d);
        highs = 0;
        shape_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            highs += int'(pwm_out);
            if (pwm_out !== (i < exp_high) || pwm_out1 !== !pwm_out) shape_bad++;
        end
    endtask

    initial begin
        int highs, bad, first;
        tbl[0] = '{25, 25};
        tbl[1] = '{0, 0};
        tbl[2] = '{100, 100};
        tbl[3] = '{127, 100};
        tbl[4] = '{1, 1};
        tbl[5] = '{99, 99};
        tbl[6] = '{50, 50};
        tbl[7] = '{101, 100};
        tbl[8] = '{0, 0};

        // Reset held with dc = 50, checked before any clock edge.
        #1;
        dc = 7'd50;
        reset = 1'b1;
        #1;
        chk("init_rst_pwm", int'(pwm_out), 0);
        chk("init_rst_pwm1", int'(pwm_out1), 0);
        repeat (3) tick();
        reset = 1'b0;
        k = 0;
        samp = 0;
        dc = 7'd25;

        // Table of full periods, each started cleanly at a period boundary.
        foreach (tbl[i]) begin
            run_period(tbl[i].dc, tbl[i].high, highs, bad);
            chk($sformatf("tbl%0d_high", i), highs, tbl[i].high);
            chk($sformatf("tbl%0d_shape", i), bad, 0);
        end

        // Duty change 25 -> 75 at cnt = 40: current period unaffected.
        align();
        dc = 7'd25;
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 40) dc = 7'd75;
            tick();
            highs += int'(pwm_out);
        end
        chk("midchg_cur_high", highs, 25);
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            highs += int'(pwm_out);
        end
        chk("midchg_next_high", highs, 75);

        // Reset pulsed at cnt = 60 with dc = 50, then a fresh period.
        align();
        dc = 7'd50;
        repeat (60) tick();
        do_reset();
        highs = 0;
        first = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) first = int'(pwm_out);
            highs += int'(pwm_out);
        end
        chk("rst_mid_first", first, 1);
        chk("rst_mid_high", highs, 50);

        // Randomized duty changes at arbitrary times, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) dc = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 999) == 0) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
